ik_swift_avalon_bridge: RTL and testbench

//  CPU-side driver for the ik_swift core: the master end of the core's en/rst/done protocol. Exposes a 32-bit

---
 rtl/ik_swift_pkg.sv | 39 +++
 rtl/ik_swift_bridge_regfile.sv | 122 ++++++++++++
 rtl/ik_swift_avalon_bridge.sv | 157 +++++++++++++++
 tb/tb_ik_swift_avalon_bridge.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ik_swift_pkg.sv
// Shared constants for the ik_swift Avalon bridge: element width and counts, register map, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ik_swift_pkg;

  // Fixed-point element width shared with the core
  localparam int W    = 36;
  localparam int N_Z  = 3;
  localparam int N_T  = 6;
  localparam int N_DH = 24;

  // Avalon word address map
  localparam logic [7:0] A_CTRL       = 8'h00;
  localparam logic [7:0] A_ITERS_DONE = 8'h01;
  localparam logic [7:0] A_JT         = 8'h02;
  localparam logic [7:0] A_ITERS      = 8'h03;
  localparam logic [7:0] A_Z_LO       = 8'h08;
  localparam logic [7:0] A_Z_HI       = 8'h0D;
  localparam logic [7:0] A_T_LO       = 8'h10;
  localparam logic [7:0] A_T_HI       = 8'h1B;
  localparam logic [7:0] A_DH_LO      = 8'h40;
  localparam logic [7:0] A_DH_HI      = 8'h6F;
  localparam logic [7:0] A_DL_LO      = 8'h80;
  localparam logic [7:0] A_DL_HI      = 8'h8B;

  // Controller states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CRST = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // Half-word view of an element: low word as-is, high nibble sign-extended to 32 bits
  function automatic logic [31:0] split_rd(input logic [W-1:0] elem, input logic hi);
    if (hi) return {{(64-W){elem[W-1]}}, elem[W-1:32]};
    return elem[31:0];
  endfunction

endpackage

// File: rtl/ik_swift_bridge_regfile.sv
// Element storage for z/target/dh/joint_type/iters, half-word write decode and read mux.
// Latency: writes take effect next cycle; read mux is combinational (registered in the top).
// Backpressure: none; writes are dropped when i_wr_en is low. Optional IK_SWIFT_DELTA_READBACK_EN adds delta capture.
module ik_swift_bridge_regfile
  import ik_swift_pkg::*;
#(
  parameter int ITER_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [7:0]          i_address,
  input  logic [31:0]         i_writedata,
  input  logic                i_cap,
  input  logic [N_DH*W-1:0]   i_dh_out,
  input  logic [N_T*W-1:0]    i_delta,
  output logic [N_Z*W-1:0]    o_z,
  output logic [5:0]          o_joint_type,
  output logic [N_T*W-1:0]    o_target,
  output logic [N_DH*W-1:0]   o_dh,
  output logic [ITER_W-1:0]   o_iters,
  output logic [31:0]         o_rdata
);

  logic [W-1:0]      r_z      [N_Z];
  logic [W-1:0]      r_target [N_T];
  logic [W-1:0]      r_dh     [N_DH];
  logic [5:0]        r_joint_type;
  logic [ITER_W-1:0] r_iters;

  logic       w_hi;
  logic       w_z_hit, w_t_hit, w_dh_hit;
  logic [1:0] w_z_idx;
  logic [2:0] w_t_idx;
  logic [4:0] w_dh_idx;

  // Odd addresses select the high nibble of an element; element index is the offset halved
  assign w_hi     = i_address[0];
  assign w_z_hit  = (i_address >= A_Z_LO)  && (i_address <= A_Z_HI);
  assign w_t_hit  = (i_address >= A_T_LO)  && (i_address <= A_T_HI);
  assign w_dh_hit = (i_address >= A_DH_LO) && (i_address <= A_DH_HI);
  assign w_z_idx  = 2'((i_address - A_Z_LO)  >> 1);
  assign w_t_idx  = 3'((i_address - A_T_LO)  >> 1);
  assign w_dh_idx = 5'((i_address - A_DH_LO) >> 1);

  // Replace either the low word or the high nibble of an element; the other half is kept
  function automatic logic [W-1:0] merge_half(input logic [W-1:0] old, input logic hi,
                                              input logic [31:0] wd);
    if (hi) return {wd[W-33:0], old[31:0]};
    return {old[W-1:32], wd};
  endfunction

  // Software writes to element storage, plus dh feedback capture from the core
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_Z; i++)  r_z[i]      <= '0;
      for (int i = 0; i < N_T; i++)  r_target[i] <= '0;
      for (int i = 0; i < N_DH; i++) r_dh[i]     <= '0;
      r_joint_type <= '0;
      r_iters      <= '0;
    end else begin
      if (i_wr_en) begin
        if (w_z_hit)  r_z[w_z_idx]      <= merge_half(r_z[w_z_idx], w_hi, i_writedata);
        if (w_t_hit)  r_target[w_t_idx] <= merge_half(r_target[w_t_idx], w_hi, i_writedata);
        if (w_dh_hit) r_dh[w_dh_idx]    <= merge_half(r_dh[w_dh_idx], w_hi, i_writedata);
        if (i_address == A_JT)    r_joint_type <= i_writedata[5:0];
        if (i_address == A_ITERS) r_iters      <= i_writedata[ITER_W-1:0];
      end
      if (i_cap) begin
        for (int i = 0; i < N_DH; i++) r_dh[i] <= i_dh_out[i*W +: W];
      end
    end
  end

`ifdef IK_SWIFT_DELTA_READBACK_EN
  logic [W-1:0] r_delta [N_T];
  logic         w_dl_hit;
  logic [2:0]   w_dl_idx;

  assign w_dl_hit = (i_address >= A_DL_LO) && (i_address <= A_DL_HI);
  assign w_dl_idx = 3'((i_address - A_DL_LO) >> 1);

  // Latch the core's delta vector alongside each dh capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_T; i++) r_delta[i] <= '0;
    end else if (i_cap) begin
      for (int i = 0; i < N_T; i++) r_delta[i] <= i_delta[i*W +: W];
    end
  end
`else
  logic w_unused_delta;
  assign w_unused_delta = ^i_delta;
`endif

  // Flatten storage onto the core-facing buses
  always_comb begin
    o_z      = '0;
    o_target = '0;
    o_dh     = '0;
    for (int i = 0; i < N_Z; i++)  o_z[i*W +: W]      = r_z[i];
    for (int i = 0; i < N_T; i++)  o_target[i*W +: W] = r_target[i];
    for (int i = 0; i < N_DH; i++) o_dh[i*W +: W]     = r_dh[i];
  end

  assign o_joint_type = r_joint_type;
  assign o_iters      = r_iters;

  // Read mux over the element region; unmapped addresses return 0
  always_comb begin
    o_rdata = '0;
    if (i_address == A_JT)         o_rdata = {26'd0, r_joint_type};
    else if (i_address == A_ITERS) o_rdata = 32'(r_iters);
    else if (w_z_hit)              o_rdata = split_rd(r_z[w_z_idx], w_hi);
    else if (w_t_hit)              o_rdata = split_rd(r_target[w_t_idx], w_hi);
    else if (w_dh_hit)             o_rdata = split_rd(r_dh[w_dh_idx], w_hi);
`ifdef IK_SWIFT_DELTA_READBACK_EN
    else if (w_dl_hit)             o_rdata = split_rd(r_delta[w_dl_idx], w_hi);
`endif
  end

endmodule

// File: rtl/ik_swift_avalon_bridge.sv
// Avalon-MM slave that sequences the ik_swift core N times, feeding dh_out back to dh_in.
// Latency: readdata registered, 1 cycle after read; each iteration = CRST + RUN + CAPT cycles.
// Backpressure: none (no waitrequest); writes to data regs and START are dropped while busy.
// Optional IK_SWIFT_DELTA_READBACK_EN exposes captured core_delta at 0x80-0x8B.
module ik_swift_avalon_bridge
  import ik_swift_pkg::*;
#(
  parameter int ITER_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_address,
  input  logic              i_write,
  input  logic              i_read,
  input  logic [31:0]       i_writedata,
  output logic [31:0]       o_readdata,
  output logic              o_irq,
  output logic              o_core_en,
  output logic              o_core_rst,
  output logic [N_Z*W-1:0]  o_core_z,
  output logic [5:0]        o_core_joint_type,
  output logic [N_T*W-1:0]  o_core_target,
  output logic [N_DH*W-1:0] o_core_dh_in,
  input  logic              i_core_done,
  input  logic [N_DH*W-1:0] i_core_dh_out,
  input  logic [N_T*W-1:0]  i_core_delta
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]        r_state;
  logic [TW-1:0]     r_timer;
  logic [ITER_W-1:0] r_iters_done;
  logic              r_done_flag;
  logic              r_err_flag;
  logic              r_rst_pulse;
  logic [31:0]       r_readdata;

  logic              w_busy;
  logic              w_ctrl_wr, w_start, w_abort, w_clr;
  logic              w_cap;
  logic              w_last;
  logic [ITER_W:0]   w_iters_next;
  logic [ITER_W-1:0] w_iters;
  logic [31:0]       w_rf_rdata;
  logic [31:0]       w_rdata;

  assign w_busy    = (r_state != S_IDLE);
  assign w_ctrl_wr = i_write && (i_address == A_CTRL);
  assign w_start   = w_ctrl_wr && i_writedata[0];
  assign w_abort   = w_ctrl_wr && i_writedata[1];
  assign w_clr     = w_ctrl_wr && i_writedata[2];

  // Capture is suppressed by a coincident ABORT so dh keeps the previous result
  assign w_cap        = (r_state == S_CAPT) && !w_abort;
  assign w_iters_next = {1'b0, r_iters_done} + 1'b1;
  assign w_last       = (w_iters_next == {1'b0, w_iters});

  ik_swift_bridge_regfile #(.ITER_W(ITER_W)) u_regfile (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr_en      (i_write && !w_busy),
    .i_address    (i_address),
    .i_writedata  (i_writedata),
    .i_cap        (w_cap),
    .i_dh_out     (i_core_dh_out),
    .i_delta      (i_core_delta),
    .o_z          (o_core_z),
    .o_joint_type (o_core_joint_type),
    .o_target     (o_core_target),
    .o_dh         (o_core_dh_in),
    .o_iters      (w_iters),
    .o_rdata      (w_rf_rdata)
  );

  // Iteration controller: START/ABORT/CLR handling, per-run timeout, flag updates
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_iters_done <= '0;
      r_done_flag  <= 1'b0;
      r_err_flag   <= 1'b0;
      r_rst_pulse  <= 1'b1;
    end else begin
      r_rst_pulse <= 1'b0;
      if (w_clr) begin
        r_done_flag <= 1'b0;
        r_err_flag  <= 1'b0;
      end
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_rst_pulse <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_err_flag   <= 1'b0;
              r_iters_done <= '0;
              if (w_iters == '0) begin
                r_done_flag <= 1'b1;
              end else begin
                r_done_flag <= 1'b0;
                r_state     <= S_CRST;
              end
            end
          end
          S_CRST: begin
            r_timer <= '0;
            r_state <= S_RUN;
          end
          S_RUN: begin
            if (i_core_done) begin
              r_state <= S_CAPT;
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
              r_err_flag <= 1'b1;
              r_state    <= S_ERR;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_CAPT: begin
            r_iters_done <= r_iters_done + 1'b1;
            if (w_last) begin
              r_done_flag <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_state <= S_CRST;
            end
          end
          S_ERR:   r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Status registers live here; everything else comes from the register file
  always_comb begin
    w_rdata = w_rf_rdata;
    if (i_address == A_CTRL)            w_rdata = {29'd0, r_err_flag, r_done_flag, w_busy};
    else if (i_address == A_ITERS_DONE) w_rdata = 32'(r_iters_done);
  end

  // Fixed one-cycle read latency; bus idles at zero between reads
  always_ff @(posedge i_clk) begin
    if (i_rst) r_readdata <= '0;
    else       r_readdata <= i_read ? w_rdata : 32'd0;
  end

  assign o_readdata = r_readdata;
  assign o_irq      = r_done_flag | r_err_flag;
  assign o_core_en  = (r_state == S_RUN);
  assign o_core_rst = (r_state == S_CRST) | r_rst_pulse;

endmodule

// File: tb/tb_ik_swift_avalon_bridge.sv
module tb_ik_swift_avalon_bridge;

  localparam int EW  = 36;
  localparam int NZ  = 3;
  localparam int NT  = 6;
  localparam int NDH = 24;
  localparam int TO  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        address;
  logic              write, read;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq, core_en, core_rst, core_done;
  logic [NZ*EW-1:0]  core_z;
  logic [5:0]        core_jt;
  logic [NT*EW-1:0]  core_target;
  logic [NDH*EW-1:0] core_dh_in, core_dh_out;
  logic [NT*EW-1:0]  core_delta;

  always #5 clk = ~clk;

  ik_swift_avalon_bridge #(.ITER_W(8), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_address(address), .i_write(write), .i_read(read),
    .i_writedata(writedata), .o_readdata(readdata), .o_irq(irq), .o_core_en(core_en),
    .o_core_rst(core_rst), .o_core_z(core_z), .o_core_joint_type(core_jt),
    .o_core_target(core_target), .o_core_dh_in(core_dh_in), .i_core_done(core_done),
    .i_core_dh_out(core_dh_out), .i_core_delta(core_delta)
  );

  // Reference state kept at the level of the register map
  logic [EW-1:0] m_z  [NZ];
  logic [EW-1:0] m_t  [NT];
  logic [EW-1:0] m_dh [NDH];
  logic [EW-1:0] m_dl [NT];
  logic [5:0]    m_jt;
  logic [EW-1:0] salt;
  logic          done_mode;
  int            rst_cnt, en_cnt, core_cnt;
  int            n_checks = 0;
  int            n_errors = 0;

  // Core stand-in: each dh element advances by (index+1+salt) per run
  for (genvar g = 0; g < NDH; g++) begin : g_core
    assign core_dh_out[g*EW +: EW] = core_dh_in[g*EW +: EW] + EW'(g + 1) + salt;
  end

  // Core stand-in timing: done after 10 enabled cycles; also counts rst pulses and en cycles
  initial begin
    core_done = 1'b0;
    core_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (core_rst) rst_cnt++;
      if (core_en)  en_cnt++;
      if (core_rst) begin
        core_cnt  = 0;
        core_done = 1'b0;
      end else if (core_en && done_mode) begin
        core_cnt++;
        core_done = (core_cnt == 10);
      end else begin
        core_done = 1'b0;
      end
    end
  end

  function automatic logic [EW-1:0] inc_of(input int j);
    return EW'(j + 1) + salt;
  endfunction

  function automatic logic [63:0] halves(input logic [EW-1:0] e);
    return {{28{e[EW-1]}}, e[EW-1:32], e[31:0]};
  endfunction

  function automatic logic [EW-1:0] rnd36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[EW-1:0];
  endfunction

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic wr_elem(input logic [7:0] a, input logic [EW-1:0] v);
    logic [31:0] junk;
    junk = $urandom();
    bus_wr(a, v[31:0]);
    bus_wr(a + 8'd1, {junk[31:4], v[EW-1:32]});
  endtask

  task automatic rd_elem(input logic [7:0] a, output logic [63:0] v);
    logic [31:0] lo, hi;
    bus_rd(a, lo);
    bus_rd(a + 8'd1, hi);
    v = {hi, lo};
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [63:0] e;
    rst = 1'b1; address = '0; write = 1'b0; read = 1'b0; writedata = '0;
    done_mode = 1'b1; salt = '0; core_delta = '0;
    for (int i = 0; i < NZ; i++)  m_z[i]  = '0;
    for (int i = 0; i < NT; i++)  m_t[i]  = '0;
    for (int i = 0; i < NDH; i++) m_dh[i] = '0;
    for (int i = 0; i < NT; i++)  m_dl[i] = '0;
    m_jt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL reset_core_rst got %b exp 1", core_rst); end
    n_checks++; if (readdata !== 32'd0) begin n_errors++; $display("FAIL reset_readdata got %h exp 0", readdata); end
    n_checks++; if (core_en !== 1'b0) begin n_errors++; $display("FAIL reset_core_en got %b exp 0", core_en); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (core_rst !== 1'b0) begin n_errors++; $display("FAIL reset_core_rst_release got %b exp 0", core_rst); end
    bus_rd(8'h00, d);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL reset_ctrl got %h exp 0", d); end
    bus_rd(8'h01, d);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL reset_iters_done got %h exp 0", d); end
    rd_elem(8'h40, e);
    n_checks++; if (e !== 64'd0) begin n_errors++; $display("FAIL reset_dh0 got %h exp 0", e); end
    rd_elem(8'h6E, e);
    n_checks++; if (e !== 64'd0) begin n_errors++; $display("FAIL reset_dh23 got %h exp 0", e); end
  endtask

  task automatic test_split_regs();
    logic [31:0] d;
    logic [63:0] e;
    logic [31:0] r;
    bus_wr(8'h0A, 32'h1234_5678);
    bus_wr(8'h0B, 32'h0000_0009);
    m_z[1] = 36'h9_1234_5678;
    n_checks++; if (core_z[EW +: EW] !== 36'h9_1234_5678) begin n_errors++; $display("FAIL z1_bus got %h exp 912345678", core_z[EW +: EW]); end
    bus_rd(8'h0B, d);
    n_checks++; if (d !== 32'hFFFF_FFF9) begin n_errors++; $display("FAIL z1_hi_read got %h exp fffffff9", d); end
    bus_rd(8'h0A, d);
    n_checks++; if (d !== 32'h1234_5678) begin n_errors++; $display("FAIL z1_lo_read got %h exp 12345678", d); end
    for (int i = 0; i < NZ; i++) begin m_z[i] = rnd36(); wr_elem(8'h08 + 8'(2*i), m_z[i]); end
    for (int i = 0; i < NT; i++) begin m_t[i] = rnd36(); wr_elem(8'h10 + 8'(2*i), m_t[i]); end
    r = $urandom();
    m_jt = r[5:0];
    bus_wr(8'h02, r);
    for (int i = 0; i < NZ; i++) begin
      n_checks++; if (core_z[i*EW +: EW] !== m_z[i]) begin n_errors++; $display("FAIL z_bus[%0d] got %h exp %h", i, core_z[i*EW +: EW], m_z[i]); end
    end
    for (int i = 0; i < NT; i++) begin
      n_checks++; if (core_target[i*EW +: EW] !== m_t[i]) begin n_errors++; $display("FAIL target_bus[%0d] got %h exp %h", i, core_target[i*EW +: EW], m_t[i]); end
      rd_elem(8'h10 + 8'(2*i), e);
      n_checks++; if (e !== halves(m_t[i])) begin n_errors++; $display("FAIL target_read[%0d] got %h exp %h", i, e, halves(m_t[i])); end
    end
    n_checks++; if (core_jt !== m_jt) begin n_errors++; $display("FAIL jt_bus got %h exp %h", core_jt, m_jt); end
    bus_rd(8'h02, d);
    n_checks++; if (d !== {26'd0, m_jt}) begin n_errors++; $display("FAIL jt_read got %h exp %h", d, m_jt); end
    bus_wr(8'h20, $urandom());
    bus_rd(8'h20, d);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL unmapped_20 got %h exp 0", d); end
    bus_rd(8'h7F, d);
    n_checks++; if (d !== 32'd0) begin n_errors++; $display("FAIL unmapped_7f got %h exp 0", d); end
  endtask

  // Run n iterations from START; optionally reload dh first, otherwise chain from previous result
  task automatic test_iterate(input int n, input bit load_dh);
    logic [31:0] d;
    logic [63:0] e;
    int cyc;
    salt = rnd36();
    for (int i = 0; i < NT; i++) core_delta[i*EW +: EW] = rnd36();
    if (load_dh) for (int j = 0; j < NDH; j++) begin m_dh[j] = rnd36(); wr_elem(8'h40 + 8'(2*j), m_dh[j]); end
    bus_wr(8'h03, 32'(n));
    rst_cnt = 0; en_cnt = 0;
    bus_wr(8'h00, 32'h1);
    cyc = 0;
    while (!irq && cyc < 3000) begin @(negedge clk); cyc++; end
    n_checks++; if (cyc >= 3000) begin n_errors++; $display("FAIL iter_wait_done got timeout exp irq"); end
    for (int it = 0; it < n; it++) for (int j = 0; j < NDH; j++) m_dh[j] = m_dh[j] + inc_of(j);
    for (int i = 0; i < NT; i++) m_dl[i] = core_delta[i*EW +: EW];
    n_checks++; if (rst_cnt !== n) begin n_errors++; $display("FAIL iter_rst_pulses got %0d exp %0d", rst_cnt, n); end
    n_checks++; if (en_cnt !== 10*n) begin n_errors++; $display("FAIL iter_en_cycles got %0d exp %0d", en_cnt, 10*n); end
    n_checks++; if (core_en !== 1'b0) begin n_errors++; $display("FAIL iter_core_en got %b exp 0", core_en); end
    bus_rd(8'h01, d);
    n_checks++; if (d !== 32'(n)) begin n_errors++; $display("FAIL iter_iters_done got %0d exp %0d", d, n); end
    bus_rd(8'h00, d);
    n_checks++; if (d !== 32'h2) begin n_errors++; $display("FAIL iter_ctrl got %h exp 2", d); end
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL iter_irq got %b exp 1", irq); end
    for (int j = 0; j < NDH; j++) begin
      n_checks++; if (core_dh_in[j*EW +: EW] !== m_dh[j]) begin n_errors++; $display("FAIL iter_dh_bus[%0d] got %h exp %h", j, core_dh_in[j*EW +: EW], m_dh[j]); end
    end
    for (int k = 0; k < 4; k++) begin
      int j;
      j = $urandom_range(NDH - 1, 0);
      rd_elem(8'h40 + 8'(2*j), e);
      n_checks++; if (e !== halves(m_dh[j])) begin n_errors++; $display("FAIL iter_dh_read[%0d] got %h exp %h", j, e, halves(m_dh[j])); end
    end
    for (int i = 0; i < NT; i++) begin
      rd_elem(8'h80 + 8'(2*i), e);
`ifdef IK_SWIFT_DELTA_READBACK_EN
      n_checks++; if (e !== halves(m_dl[i])) begin n_errors++; $display("FAIL delta_read[%0d] got %h exp %h", i, e, halves(m_dl[i])); end
`else
      n_checks++; if (e !== 64'd0) begin n_errors++; $display("FAIL delta_read[%0d] got %h exp 0", i, e); end
`endif
    end
  endtask

  task automatic test_zero_iters();
    logic [31:0] d;
    bus_wr(8'h00, 32'h4);
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL clr_irq got %b exp 0", irq); end
    bus_wr(8'h03, 32'h0);
    rst_cnt = 0; en_cnt = 0;
    bus_wr(8'h00, 32'h1);
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL zero_irq_next got %b exp 1", irq); end
    bus_rd(8'h00, d);
    n_checks++; if (d !== 32'h2) begin n_errors++; $display("FAIL zero_ctrl got %h exp 2", d); end
    repeat (20) @(negedge clk);
    n_checks++; if (en_cnt !== 0) begin n_errors++; $display("FAIL zero_en_cycles got %0d exp 0", en_cnt); end
    n_checks++; if (rst_cnt !== 0) begin n_errors++; $display("FAIL zero_rst_pulses got %0d exp 0", rst_cnt); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int cyc;
    bus_wr(8'h00, 32'h4);
    done_mode = 1'b0;
    bus_wr(8'h03, 32'h1);
    rst_cnt = 0; en_cnt = 0;
    bus_wr(8'h00, 32'h1);
    cyc = 0;
    while (!irq && cyc < 500) begin @(negedge clk); cyc++; end
    n_checks++; if (cyc >= 500) begin n_errors++; $display("FAIL to_wait_err got timeout exp irq"); end
    n_checks++; if (en_cnt !== TO) begin n_errors++; $display("FAIL to_en_cycles got %0d exp %0d", en_cnt, TO); end
    n_checks++; if (core_en !== 1'b0) begin n_errors++; $display("FAIL to_core_en got %b exp 0", core_en); end
    bus_rd(8'h00, d);
    n_checks++; if (d !== 32'h4) begin n_errors++; $display("FAIL to_ctrl got %h exp 4", d); end
    bus_rd(8'h01, d);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL to_iters_done got %h exp 0", d); end
    for (int j = 0; j < NDH; j++) begin
      n_checks++; if (core_dh_in[j*EW +: EW] !== m_dh[j]) begin n_errors++; $display("FAIL to_dh_hold[%0d] got %h exp %h", j, core_dh_in[j*EW +: EW], m_dh[j]); end
    end
    done_mode = 1'b1;
    bus_wr(8'h00, 32'h4);
    bus_rd(8'h00, d);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL to_clr_ctrl got %h exp 0", d); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL to_clr_irq got %b exp 0", irq); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int cyc, en_snap;
    salt = rnd36();
    bus_wr(8'h03, 32'h3);
    rst_cnt = 0; en_cnt = 0;
    bus_wr(8'h00, 32'h1);
    // Writes while busy must be dropped
    bus_wr(8'h03, 32'h7);
    bus_wr(8'h08, $urandom());
    bus_wr(8'h02, $urandom());
    bus_wr(8'h41, $urandom());
    bus_wr(8'h00, 32'h1);
    cyc = 0;
    while (!(rst_cnt >= 2 && en_cnt >= 13) && cyc < 500) begin @(negedge clk); cyc++; end
    n_checks++; if (cyc >= 500) begin n_errors++; $display("FAIL ab_wait_iter2 got timeout exp run2"); end
    rst_cnt = 0;
    bus_wr(8'h00, 32'h3);
    n_checks++; if (core_en !== 1'b0) begin n_errors++; $display("FAIL ab_core_en got %b exp 0", core_en); end
    n_checks++; if (core_rst !== 1'b1) begin n_errors++; $display("FAIL ab_core_rst got %b exp 1", core_rst); end
    en_snap = en_cnt;
    repeat (10) @(negedge clk);
    n_checks++; if (rst_cnt !== 1) begin n_errors++; $display("FAIL ab_rst_pulses got %0d exp 1", rst_cnt); end
    n_checks++; if (en_cnt !== en_snap) begin n_errors++; $display("FAIL ab_en_after got %0d exp %0d", en_cnt, en_snap); end
    bus_rd(8'h01, d);
    n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL ab_iters_done got %h exp 1", d); end
    bus_rd(8'h00, d);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL ab_ctrl got %h exp 0", d); end
    bus_rd(8'h03, d);
    n_checks++; if (d !== 32'h3) begin n_errors++; $display("FAIL ab_iters_kept got %h exp 3", d); end
    n_checks++; if (core_z[0 +: EW] !== m_z[0]) begin n_errors++; $display("FAIL ab_z0_kept got %h exp %h", core_z[0 +: EW], m_z[0]); end
    n_checks++; if (core_jt !== m_jt) begin n_errors++; $display("FAIL ab_jt_kept got %h exp %h", core_jt, m_jt); end
    for (int j = 0; j < NDH; j++) m_dh[j] = m_dh[j] + inc_of(j);
    for (int j = 0; j < NDH; j++) begin
      n_checks++; if (core_dh_in[j*EW +: EW] !== m_dh[j]) begin n_errors++; $display("FAIL ab_dh[%0d] got %h exp %h", j, core_dh_in[j*EW +: EW], m_dh[j]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) test_iterate($urandom_range(4, 1), 1'b0);
  endtask

  initial begin
    test_reset();
    test_split_regs();
    test_iterate(3, 1'b1);
    test_zero_iters();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
